// File: rtl/pmp_csr_file_pkg.sv
// pmp_csr_file_pkg: shared PMP types, CSR bases and the per-byte cfg legalisation rule
package pmp_csr_file_pkg;
  typedef enum logic [1:0] {A_OFF, A_TOR, A_NA4, A_NAPOT} pmp_a_e;
  typedef struct packed {
    logic       lock;
    logic [1:0] rsv;
    pmp_a_e     a;
    logic       x;
    logic       w;
    logic       r;
  } pmp_cfg_t;
  typedef enum logic {S_IDLE, S_UPD} upd_state_e;
  localparam logic [1:0] MACHINE = 2'b11;
  localparam logic [11:0] PMPCFG_BASE = 12'h3A0;
  localparam logic [11:0] PMPADDR_BASE = 12'h3B0;
  // Locked bytes keep their value; reserved bits read 0; R=0,W=1 is illegal so W drops.
  function automatic pmp_cfg_t cfg_warl(input pmp_cfg_t old, input logic [7:0] wb);
    return old.lock ? old : '{lock: wb[7], rsv: 2'b00, a: pmp_a_e'(wb[4:3]), x: wb[2], w: wb[1] & wb[0], r: wb[0]};
  endfunction
endpackage

// File: rtl/pmp_csr_file_if.sv
// pmp_csr_file_if: CSR unit request/response channel into the PMP register file
interface pmp_csr_file_if;
  logic        csr_req_vld;
  logic        csr_req_rdy;
  logic        csr_req_wr;
  logic [11:0] csr_req_addr;
  logic [31:0] csr_req_wdata;
  logic        csr_rsp_vld;
  logic        csr_rsp_hit;
  logic [31:0] csr_rsp_rdata;
  modport master (output csr_req_vld, csr_req_wr, csr_req_addr, csr_req_wdata,
                  input csr_req_rdy, csr_rsp_vld, csr_rsp_hit, csr_rsp_rdata);
  modport slave (input csr_req_vld, csr_req_wr, csr_req_addr, csr_req_wdata,
                 output csr_req_rdy, csr_rsp_vld, csr_rsp_hit, csr_rsp_rdata);
endinterface

// File: rtl/pmp_csr_file_napot_mask_gen.sv
// pmp_csr_file_napot_mask_gen: clears the trailing-ones+1 LSBs of pmpaddr to form the NAPOT mask
module pmp_csr_file_napot_mask_gen #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [ADDR_WIDTH-1:0] mask_o
);
  assign mask_o = ~(addr_i ^ (addr_i + ADDR_WIDTH'(1)));
endmodule

// File: rtl/pmp_csr_file.sv
// pmp_csr_file: owns pmpcfg/pmpaddr state, applies WARL and lock rules, and
// refreshes the NAPOT mask of the written entry in a one-cycle update state.
module pmp_csr_file
  import pmp_csr_file_pkg::*;
#(
  parameter int PMP_CHANNEL_NUM = 32,
  parameter int ADDR_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pmp_csr_file_if.slave         csr,
  output logic                  pmp_update_busy_o,
  output pmp_cfg_t              v_pmp_cfg_o        [PMP_CHANNEL_NUM],
  output logic [ADDR_WIDTH-1:0] v_pmp_addr_o       [PMP_CHANNEL_NUM],
  output logic [ADDR_WIDTH-1:0] v_pmp_napot_mask_o [PMP_CHANNEL_NUM]
);
  localparam int NCFG = PMP_CHANNEL_NUM / 4;
  localparam int IW   = $clog2(PMP_CHANNEL_NUM);
  upd_state_e            state_q, state_d;
  pmp_cfg_t              cfg_q  [PMP_CHANNEL_NUM];
  pmp_cfg_t              cfg_d  [PMP_CHANNEL_NUM];
  logic [ADDR_WIDTH-1:0] addr_q [PMP_CHANNEL_NUM];
  logic [ADDR_WIDTH-1:0] addr_d [PMP_CHANNEL_NUM];
  logic [ADDR_WIDTH-1:0] mask_q [PMP_CHANNEL_NUM];
  logic [ADDR_WIDTH-1:0] mask_new;
  logic [IW-1:0]         upd_idx_q, upd_idx_d, aidx;
  logic [11:0]           aoff;
  logic [3:0]            cfg_n;
  logic [31:0]           cfg_word, rdata, rsp_rdata_q;
  logic                  acc, cfg_hit, addr_hit, addr_lock, rsp_vld_q, rsp_hit_q;
  assign acc      = csr.csr_req_vld && state_q == S_IDLE;
  assign cfg_n    = csr.csr_req_addr[3:0];
  assign cfg_hit  = csr.csr_req_addr[11:4] == PMPCFG_BASE[11:4] && {1'b0, cfg_n} < 5'(NCFG);
  assign aoff     = csr.csr_req_addr - PMPADDR_BASE;
  assign addr_hit = csr.csr_req_addr >= PMPADDR_BASE && aoff < 12'(PMP_CHANNEL_NUM);
  assign aidx     = aoff[IW-1:0];
  // A TOR entry above also guards this entry's pmpaddr, as it forms its lower bound.
  assign addr_lock = cfg_q[aidx].lock || (aidx != IW'(PMP_CHANNEL_NUM - 1) &&
                     cfg_q[aidx + 1'b1].lock && cfg_q[aidx + 1'b1].a == A_TOR);
  assign rdata = cfg_hit ? cfg_word : addr_hit ? 32'(addr_q[aidx]) : 32'h0;
  always_comb begin
    state_d   = state_q;
    upd_idx_d = upd_idx_q;
    cfg_d     = cfg_q;
    addr_d    = addr_q;
    cfg_word  = '0;
    for (int k = 0; k < 4; k++) cfg_word[8*k +: 8] = cfg_q[IW'({cfg_n, 2'(k)})] & 8'h9F;
    if (state_q == S_UPD) state_d = S_IDLE;
    else if (acc && csr.csr_req_wr && (cfg_hit || addr_hit)) begin
      state_d   = S_UPD;
      upd_idx_d = cfg_hit ? IW'({cfg_n, 2'b00}) : aidx;
      if (cfg_hit)
        for (int k = 0; k < 4; k++)
          cfg_d[IW'({cfg_n, 2'(k)})] = cfg_warl(cfg_q[IW'({cfg_n, 2'(k)})], csr.csr_req_wdata[8*k +: 8]);
      else if (!addr_lock) addr_d[aidx] = ADDR_WIDTH'(csr.csr_req_wdata);
    end
  end
  pmp_csr_file_napot_mask_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_mask_gen (
    .addr_i (addr_q[upd_idx_q]),
    .mask_o (mask_new)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      upd_idx_q   <= '0;
      rsp_vld_q   <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_rdata_q <= '0;
      for (int i = 0; i < PMP_CHANNEL_NUM; i++) begin
        cfg_q[i]  <= '0;
        addr_q[i] <= '0;
        mask_q[i] <= ~ADDR_WIDTH'(1);
      end
    end else begin
      state_q   <= state_d;
      upd_idx_q <= upd_idx_d;
      cfg_q     <= cfg_d;
      addr_q    <= addr_d;
      rsp_vld_q <= acc;
      if (acc) begin
        rsp_hit_q   <= cfg_hit || addr_hit;
        rsp_rdata_q <= rdata;
      end
      if (state_q == S_UPD) mask_q[upd_idx_q] <= mask_new;
    end
  end
  assign csr.csr_req_rdy   = state_q == S_IDLE;
  assign csr.csr_rsp_vld   = rsp_vld_q;
  assign csr.csr_rsp_hit   = rsp_hit_q;
  assign csr.csr_rsp_rdata = rsp_rdata_q;
  assign pmp_update_busy_o = state_q == S_UPD;
  assign v_pmp_cfg_o        = cfg_q;
  assign v_pmp_addr_o       = addr_q;
  assign v_pmp_napot_mask_o = mask_q;
endmodule

// File: tb/tb_pmp_csr_file.sv
// tb_pmp_csr_file: directed CSR accesses with hand-computed expectations
module tb_pmp_csr_file;
  import pmp_csr_file_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  pmp_cfg_t    cfg_o  [32];
  logic [31:0] addr_o [32];
  logic [31:0] mask_o [32];
  int checks = 0;
  int failures = 0;
  logic        r_vld, r_hit, r_busy, r_rdy, n_vld, n_busy, n_rdy;
  logic [31:0] r_rdata;
  pmp_csr_file_if bus();
  pmp_csr_file #(.PMP_CHANNEL_NUM(32), .ADDR_WIDTH(32)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .csr                (bus),
    .pmp_update_busy_o  (busy),
    .v_pmp_cfg_o        (cfg_o),
    .v_pmp_addr_o       (addr_o),
    .v_pmp_napot_mask_o (mask_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // One access: sample the response cycle, then the following cycle.
  task automatic access(input logic wr, input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.csr_req_vld   = 1'b1;
    bus.csr_req_wr    = wr;
    bus.csr_req_addr  = a;
    bus.csr_req_wdata = d;
    @(posedge clk);
    #1;
    bus.csr_req_vld = 1'b0;
    r_vld = bus.csr_rsp_vld; r_hit = bus.csr_rsp_hit; r_rdata = bus.csr_rsp_rdata;
    r_busy = busy; r_rdy = bus.csr_req_rdy;
    @(posedge clk);
    #1;
    n_vld = bus.csr_rsp_vld; n_busy = busy; n_rdy = bus.csr_req_rdy;
  endtask
  task automatic rd(input string tag, input logic [11:0] a, input logic hit, input logic [31:0] exp);
    access(1'b0, a, 32'h0);
    chk({tag, "_vld"}, 32'(r_vld), 32'h1);
    chk({tag, "_hit"}, 32'(r_hit), 32'(hit));
    chk({tag, "_rdata"}, r_rdata, exp);
    chk({tag, "_nobusy"}, 32'(r_busy), 32'h0);
  endtask
  task automatic wr(input string tag, input logic [11:0] a, input logic [31:0] d, input logic [31:0] pre);
    access(1'b1, a, d);
    chk({tag, "_vld"}, 32'(r_vld), 32'h1);
    chk({tag, "_hit"}, 32'(r_hit), 32'h1);
    chk({tag, "_pre"}, r_rdata, pre);
    chk({tag, "_busy"}, {30'h0, r_busy, r_rdy}, 32'h2);
    chk({tag, "_after"}, {29'h0, n_vld, n_busy, n_rdy}, 32'h1);
  endtask
  initial begin
    bus.csr_req_vld = 1'b0; bus.csr_req_wr = 1'b0; bus.csr_req_addr = '0; bus.csr_req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_rdy", 32'(bus.csr_req_rdy), 32'h1);
    chk("rst_rsp", {30'h0, bus.csr_rsp_vld, bus.csr_rsp_hit}, 32'h0);
    chk("rst_rdata", bus.csr_rsp_rdata, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_mask3", mask_o[3], 32'hFFFF_FFFE);
    chk("rst_cfg0", 32'(cfg_o[0]), 32'h0);
    rd("rd_cfg0", 12'h3A0, 1'b1, 32'h0);
    chk("rd_after_idle", {29'h0, n_vld, n_busy, n_rdy}, 32'h1);
    rd("rd_addr5", 12'h3B5, 1'b1, 32'h0);
    rd("rd_3f0", 12'h3F0, 1'b0, 32'h0);
    rd("rd_cfg8", 12'h3A8, 1'b0, 32'h0);
    rd("rd_addr31", 12'h3CF, 1'b1, 32'h0);
    rd("rd_addr32", 12'h3D0, 1'b0, 32'h0);
    access(1'b1, 12'h3D0, 32'hDEAD_BEEF);
    chk("wr_miss", {28'h0, r_vld, r_hit, r_busy, r_rdy}, 32'h9);
    wr("wr_a3", 12'h3B3, 32'h0000_0FFF, 32'h0);
    chk("mask3_fff", mask_o[3], 32'hFFFF_E000);
    rd("rd_a3", 12'h3B3, 1'b1, 32'h0000_0FFF);
    wr("wr_c0_82", 12'h3A0, 32'h0000_0082, 32'h0);
    chk("cfg0_80", 32'(cfg_o[0]), 32'h80);
    wr("wr_c0_07", 12'h3A0, 32'h0000_0007, 32'h80);
    rd("rd_c0_lock", 12'h3A0, 1'b1, 32'h0000_0080);
    wr("wr_c0_mix", 12'h3A0, 32'h0088_6307, 32'h80);
    rd("rd_c0_mix", 12'h3A0, 1'b1, 32'h0088_0380);
    wr("wr_a1_tor", 12'h3B1, 32'h0000_1234, 32'h0);
    rd("rd_a1_tor", 12'h3B1, 1'b1, 32'h0);
    wr("wr_a0_lock", 12'h3B0, 32'h0000_AAAA, 32'h0);
    rd("rd_a0_lock", 12'h3B0, 1'b1, 32'h0);
    wr("wr_a3_ok", 12'h3B3, 32'h0000_1234, 32'h0000_0FFF);
    chk("addr3_1234", addr_o[3], 32'h0000_1234);
    chk("mask3_1234", mask_o[3], 32'hFFFF_FFFE);
    wr("wr_c1_ff", 12'h3A1, 32'hFFFF_FFFF, 32'h0);
    rd("rd_c1_9f", 12'h3A1, 1'b1, 32'h9F9F_9F9F);
    wr("wr_c1_0", 12'h3A1, 32'h0, 32'h9F9F_9F9F);
    chk("cfg5_keep", 32'(cfg_o[5]), 32'h9F);
    for (int i = 4; i < 8; i++) begin
      wr("wr_a4_7", 12'(12'h3B0 + i), 32'h0000_5555, 32'h0);
      chk("addr4_7_lock", addr_o[i], 32'h0);
    end
    wr("wr_a3_napot", 12'h3B3, 32'h0000_00FF, 32'h0000_1234);
    chk("mask3_ff", mask_o[3], 32'hFFFF_FE00);
    wr("wr_a8_ones", 12'h3B8, 32'hFFFF_FFFF, 32'h0);
    chk("mask8_ones", mask_o[8], 32'h0);
    wr("wr_a31", 12'h3CF, 32'h0000_0007, 32'h0);
    chk("mask31", mask_o[31], 32'hFFFF_FFF0);
    wr("wr_c7_tor", 12'h3A7, 32'h8800_0000, 32'h0);
    wr("wr_a30_tor", 12'h3CE, 32'h0000_0033, 32'h0);
    chk("addr30_lock", addr_o[30], 32'h0);
    wr("wr_a31_lock", 12'h3CF, 32'h0000_00FF, 32'h0000_0007);
    chk("addr31_lock", addr_o[31], 32'h0000_0007);
    @(negedge clk);
    bus.csr_req_vld = 1'b1; bus.csr_req_wr = 1'b1; bus.csr_req_addr = 12'h3B9; bus.csr_req_wdata = 32'hF;
    @(posedge clk);
    #1;
    bus.csr_req_vld = 1'b0;
    chk("mid_busy", 32'(busy), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_state", {29'h0, busy, bus.csr_req_rdy, bus.csr_rsp_vld}, 32'h2);
    chk("mrst_rsp", {bus.csr_rsp_rdata[30:0], bus.csr_rsp_hit}, 32'h0);
    chk("mrst_cfg0", 32'(cfg_o[0]), 32'h0);
    chk("mrst_addr3", addr_o[3], 32'h0);
    chk("mrst_mask3", mask_o[3], 32'hFFFF_FFFE);
    chk("mrst_addr9", addr_o[9], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_norsp", {30'h0, bus.csr_rsp_vld, busy}, 32'h0);
    rd("rd_post_rst", 12'h3A1, 1'b1, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
